// File: rtl/ps2_cursor_pkg.sv
// Shared constants and the PS/2 delta decode helper for the cursor controller.
package ps2_cursor_pkg;

    localparam int L   = 0;
    localparam int R   = 1;
    localparam int M   = 2;
    localparam int ONE = 3;
    localparam int XS  = 4;
    localparam int YS  = 5;
    localparam int XV  = 6;
    localparam int YV  = 7;

    localparam logic signed [8:0] DX_SAT_POS = 9'sh0FF;   // +255
    localparam logic signed [8:0] DX_SAT_NEG = 9'sh100;   // -256

    localparam int DELTA_W = 12;

    // gain = 2^gain_sel / 2^FRAC_BITS; names assume the default FRAC_BITS of 2
    localparam logic [1:0] GAIN_QUARTER = 2'd0;
    localparam logic [1:0] GAIN_HALF    = 2'd1;
    localparam logic [1:0] GAIN_UNITY   = 2'd2;
    localparam logic [1:0] GAIN_DOUBLE  = 2'd3;

    function automatic logic signed [8:0] decode_delta(input logic sign,
                                                       input logic ovf,
                                                       input logic [7:0] mag);
        if (ovf)
            return sign ? DX_SAT_NEG : DX_SAT_POS;
        return {sign, mag};
    endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: fixed-point accumulator with clamp to [0, RES-1] and recenter.
module ps2_axis_accum #(
    parameter int RES       = 640,
    parameter int POS_W     = 10,
    parameter int FRAC_BITS = 2,
    parameter bit INVERT    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                recenter,
    input  logic                update,
    input  logic signed [11:0]  delta,
    output logic [POS_W-1:0]    pos
);
    localparam int AW = POS_W + FRAC_BITS + 2;
    localparam logic signed [AW-1:0] CENTER   = AW'((RES / 2) << FRAC_BITS);
    localparam logic signed [AW-1:0] CLAMP_HI = AW'((RES - 1) << FRAC_BITS);
    localparam logic signed [AW-1:0] MAX_INT  = AW'(RES - 1);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] delta_ext;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] int_part;

    always_comb begin
        delta_ext = {{(AW - 12){delta[11]}}, delta};
        acc_sum   = INVERT ? (acc - delta_ext) : (acc + delta_ext);
        int_part  = acc_sum >>> FRAC_BITS;
    end

    // A clamp snaps to the pixel edge with zero fraction so the cursor does not creep back
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= CENTER;
        end else if (recenter) begin
            acc <= CENTER;
        end else if (update) begin
            if (acc_sum[AW-1])
                acc <= '0;
            else if (int_part > MAX_INT)
                acc <= CLAMP_HI;
            else
                acc <= acc_sum;
        end
    end

    assign pos = acc[FRAC_BITS +: POS_W];

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// PS/2 packet to clamped cursor position, two-stage pipeline with gain, buttons and double click.
// Define PS2_WHEEL_EN to add the IntelliMouse wheel byte (packet4, wheel_delta, wheel_pulse).
module ps2_cursor_ctrl #(
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int POS_W         = 10,
    parameter int FRAC_BITS     = 2,
    parameter int DBL_CLICK_CYC = 30000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              packet_done,
    input  logic [7:0]        packet1,
    input  logic [7:0]        packet2,
    input  logic [7:0]        packet3,
    input  logic [1:0]        gain_sel,
    input  logic              recenter,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos,
    output logic              pos_valid,
    output logic [2:0]        btn_state,
    output logic [2:0]        btn_press,
    output logic [2:0]        btn_release,
    output logic              dbl_click,
    output logic              pkt_err
`ifdef PS2_WHEEL_EN
    ,
    input  logic [7:0]        packet4,
    output logic signed [3:0] wheel_delta,
    output logic              wheel_pulse
`endif
);
    import ps2_cursor_pkg::*;

    localparam int TW = $clog2(DBL_CLICK_CYC + 1);
    localparam logic [TW-1:0] DBL_MAX = TW'(DBL_CLICK_CYC);

    logic                      accept;
    logic signed [8:0]         dx_raw;
    logic signed [8:0]         dy_raw;
    logic signed [DELTA_W-1:0] dx_scaled;
    logic signed [DELTA_W-1:0] dy_scaled;

    logic                      s1_valid;
    logic signed [DELTA_W-1:0] s1_dx;
    logic signed [DELTA_W-1:0] s1_dy;
    logic [2:0]                s1_btn;

    logic [TW-1:0]             dbl_timer;
    logic                      left_press;

    always_comb begin
        accept    = packet_done & packet1[ONE];
        dx_raw    = decode_delta(packet1[XS], packet1[XV], packet2);
        dy_raw    = decode_delta(packet1[YS], packet1[YV], packet3);
        dx_scaled = {{(DELTA_W - 9){dx_raw[8]}}, dx_raw} <<< gain_sel;
        dy_scaled = {{(DELTA_W - 9){dy_raw[8]}}, dy_raw} <<< gain_sel;
    end

    // Stage 1: a packet without the always-one bit is dropped and only flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            pkt_err  <= 1'b0;
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_btn   <= '0;
        end else begin
            s1_valid <= accept;
            pkt_err  <= packet_done & ~packet1[ONE];
            if (accept) begin
                s1_dx  <= dx_scaled;
                s1_dy  <= dy_scaled;
                s1_btn <= {packet1[M], packet1[R], packet1[L]};
            end
        end
    end

    ps2_axis_accum #(
        .RES       (H_RES),
        .POS_W     (POS_W),
        .FRAC_BITS (FRAC_BITS),
        .INVERT    (1'b0)
    ) x_axis (
        .clk      (clk),
        .reset    (reset),
        .recenter (recenter),
        .update   (s1_valid),
        .delta    (s1_dx),
        .pos      (x_pos)
    );

    // PS/2 reports up as positive, the screen grows downward
    ps2_axis_accum #(
        .RES       (V_RES),
        .POS_W     (POS_W),
        .FRAC_BITS (FRAC_BITS),
        .INVERT    (1'b1)
    ) y_axis (
        .clk      (clk),
        .reset    (reset),
        .recenter (recenter),
        .update   (s1_valid),
        .delta    (s1_dy),
        .pos      (y_pos)
    );

    assign left_press = s1_valid & s1_btn[0] & ~btn_state[0];

    // Stage 2 buttons; the timer parks at DBL_MAX after a double click so a third press starts over
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_valid   <= 1'b0;
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            dbl_click   <= 1'b0;
            dbl_timer   <= DBL_MAX;
        end else begin
            pos_valid   <= s1_valid | recenter;
            btn_press   <= s1_valid ? (s1_btn & ~btn_state) : 3'b000;
            btn_release <= s1_valid ? (~s1_btn & btn_state) : 3'b000;
            if (s1_valid)
                btn_state <= s1_btn;
            dbl_click <= left_press && (dbl_timer < DBL_MAX);
            if (left_press)
                dbl_timer <= (dbl_timer < DBL_MAX) ? DBL_MAX : '0;
            else if (dbl_timer < DBL_MAX)
                dbl_timer <= dbl_timer + 1'b1;
        end
    end

`ifdef PS2_WHEEL_EN
    logic signed [3:0] s1_wheel;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_wheel    <= '0;
            wheel_delta <= '0;
            wheel_pulse <= 1'b0;
        end else begin
            if (accept)
                s1_wheel <= packet4[3:0];
            wheel_delta <= s1_valid ? s1_wheel : 4'sd0;
            wheel_pulse <= s1_valid && (s1_wheel != 4'sd0);
        end
    end
`endif

endmodule

// File: doc/ps2_cursor_ctrl.md
Name: ps2_cursor_ctrl

Overview:
Parametrised successor to the PS/2 XY accumulator. It takes decoded 3-byte mouse packets and maintains a clamped screen cursor position. Compared with the earlier block it adds a 2-stage pipeline, a selectable fixed-point pointer gain with sub-pixel remainder, packet sanity checking, button press/release edge pulses, left-button double-click detection and a recenter command. It sits between ps2_packet and the VGA cursor overlay and UI logic.

Parameters:
H_RES, 640, horizontal resolution; x clamps to [0, H_RES-1]
V_RES, 480, vertical resolution; y clamps to [0, V_RES-1]
POS_W, 10, width of x_pos/y_pos; must satisfy 2^POS_W >= max(H_RES, V_RES)
FRAC_BITS, 2, sub-pixel fraction bits in the position accumulators
DBL_CLICK_CYC, 30000000, max clocks between two left presses that count as a double click (300 ms at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
packet_done  in  1  one-cycle strobe: packet1..3 valid
packet1  in  8  status byte [YV,XV,YS,XS,1,M,R,L]
packet2  in  8  X magnitude
packet3  in  8  Y magnitude
gain_sel  in  2  gain = 2^gain_sel / 2^FRAC_BITS; sampled with the packet
recenter  in  1  one-cycle strobe: move cursor to (H_RES/2, V_RES/2)
x_pos  out  POS_W  cursor X
y_pos  out  POS_W  cursor Y (VGA orientation, down is positive)
pos_valid  out  1  one-cycle pulse when x_pos/y_pos were updated
btn_state  out  3  {M,R,L} levels
btn_press  out  3  one-cycle rising-edge pulses
btn_release  out  3  one-cycle falling-edge pulses
dbl_click  out  1  one-cycle pulse on a left double click
pkt_err  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset (synchronous, active-high; clk is the only clock):
  - x_pos = H_RES/2 and y_pos = V_RES/2, fractions = 0.
  - All pulses = 0, btn_state = 0.
  - Pipeline valid flags = 0, double-click timer saturated (no pending press).
- Stage 1 (register on packet_done):
  - If packet1[3] = 0: discard; pkt_err pulses the next cycle; no other output changes.
  - Otherwise decode 9-bit signed dx and dy:
    - overflow bit set -> saturate to -256 if the sign bit is set, else +255;
    - otherwise {sign, magnitude}.
  - Then shift left by gain_sel to get a 12-bit signed value.
  - Register the scaled dx/dy and the buttons.
- Stage 2:
  - Work in signed accumulators of POS_W+FRAC_BITS+2 bits.
  - acc_x += sdx and acc_y -= sdy; Y is inverted because PS/2 up is positive.
  - Clamp the integer part to [0, RES-1]. When a clamp occurs, clear that axis's fraction.
  - Register the outputs; pos_valid pulses.
- Latency: x_pos/y_pos/pos_valid/button pulses appear 2 clocks after packet_done; pkt_err appears 1 clock after.
- Throughput: one packet per clock; back-to-back strobes are all processed in order. No backpressure.
- Buttons: btn_press = new & ~old and btn_release = ~new & old, updated in stage 2. Every accepted packet updates btn_state, including zero-motion packets.
- Double click:
  - The timer counts clocks since the last left press and saturates at DBL_CLICK_CYC.
  - On a left press with timer < DBL_CLICK_CYC: dbl_click pulses and the timer saturates, so a third press does not re-trigger.
  - Otherwise the timer restarts at 0.
- Recenter:
  - Takes effect the next clock: position = centre, fractions = 0, pos_valid pulses.
  - If a stage-2 update coincides, recenter wins; that packet's motion is dropped but its buttons still update.
  - Priority: reset > recenter > update.
- Zero-motion packet: position unchanged, pos_valid still pulses.

Optional Feature:
PS2_WHEEL_EN:
- Defined:
  - Adds input packet4[7:0] (IntelliMouse Z byte, low 4 bits two's complement) and output wheel_delta[3:0] signed.
  - Adds output wheel_pulse, asserted with pos_valid when wheel_delta is nonzero.
  - The packet_done strobe then qualifies 4 bytes.
- Undefined: the ports are absent; behaviour is as above.

Decomposition:
- Package ps2_cursor_pkg holds:
  - the status-bit index constants (L, R, M, ONE, XS, YS, XV, YV);
  - the DX_SAT_POS = 255 and DX_SAT_NEG = -256 constants;
  - the gain_sel encoding constants.
- One natural sub-module, ps2_axis_accum, instantiated twice (X, Y): it holds the fixed-point accumulator, the clamp and the fraction clear, and takes parameters RES and an INVERT flag.

Test Plan:
- gain_sel=2 (gain 1), packet 0x08,0x05,0x03 -> 2 clocks later x=325, y=237, pos_valid=1 for one cycle.
- packet 0x58,0x00,0x00 twice -> x 320->64->0 (clamped); a following 0x08,0x01,0x00 -> x=1.
- gain_sel=0 (gain 1/4), four packets 0x08,0x01,0x00 -> x stays 320 for 3 updates and becomes 321 on the 4th.
- packet1=0x00 -> pkt_err pulse at +1 clock, no pos_valid, position unchanged.
- With DBL_CLICK_CYC=100: left press/release/press 50 clocks apart -> dbl_click pulses once; a third press at +60 gives no pulse; presses 150 apart give no pulse.
- recenter asserted in the same cycle stage 2 updates a motion packet with L=1 -> position=(320,240), btn_press[0]=1, motion ignored.
